// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming KxK sliding-window generator with K-1 line buffers
// Optional backpressure (out_ready) is compiled in with `define CONV_WINDOW_GEN_BP_EN.
module conv_window_gen #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
`ifdef CONV_WINDOW_GEN_BP_EN
  input  logic                       out_ready,
`endif
  output logic [DATA_W*K*K-1:0]      out_window,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = $clog2(STRIDE) + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] col_ph, row_ph, cur_col_ph, cur_row_ph;
  logic [CW-1:0] oc_cnt, cur_oc;
  logic [RW-1:0] or_cnt, cur_or;
  logic          accept, complete;

  logic [DATA_W-1:0] lb   [K-1][IMG_W];
  logic [DATA_W-1:0] hist [K][K-1];
  logic [DATA_W-1:0] colv [K];
  logic [DATA_W-1:0] nwin [K][K];
  logic [DATA_W*K*K-1:0] win_flat;

`ifdef CONV_WINDOW_GEN_BP_EN
  assign in_ready = !out_valid || out_ready;
`else
  assign in_ready = 1'b1;
`endif

  assign accept = in_valid && in_ready;

  // Stride phase restarts at the first column/row that can end a window.
  assign cur_col_ph = (col == COL_KM1) ? '0 : col_ph;
  assign cur_oc     = (col == COL_KM1) ? '0 : oc_cnt;
  assign cur_row_ph = (row == ROW_KM1) ? '0 : row_ph;
  assign cur_or     = (row == ROW_KM1) ? '0 : or_cnt;

  assign complete = (col >= COL_KM1) && (row >= ROW_KM1) &&
                    (cur_col_ph == '0) && (cur_row_ph == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
      oc_cnt <= '0;
      or_cnt <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col    <= '0;
        col_ph <= '0;
        oc_cnt <= '0;
        row    <= (row == ROW_LAST) ? '0 : row + RW'(1);
        if (row >= ROW_KM1) begin
          if (cur_row_ph == PH_LAST) begin
            row_ph <= '0;
            or_cnt <= cur_or + RW'(1);
          end else begin
            row_ph <= cur_row_ph + PW'(1);
            or_cnt <= cur_or;
          end
        end
      end else begin
        col <= col + CW'(1);
        if (col >= COL_KM1) begin
          if (cur_col_ph == PH_LAST) begin
            col_ph <= '0;
            oc_cnt <= cur_oc + CW'(1);
          end else begin
            col_ph <= cur_col_ph + PW'(1);
            oc_cnt <= cur_oc;
          end
        end
      end
    end
  end

  // Column entering the window: K-1 buffered rows (oldest first) plus the new pixel.
  always_comb begin
    for (int r = 0; r < K - 1; r++) colv[r] = lb[r][col];
    colv[K-1] = in_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) nwin[r][c] = hist[r][c];
      nwin[r][K-1] = colv[r];
    end
    win_flat = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_flat[(r*K+c)*DATA_W +: DATA_W] = nwin[r][c];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K - 2; i++) lb[i][col] <= lb[i+1][col];
      lb[K-2][col] <= in_data;
      for (int r = 0; r < K; r++)
        for (int j = 0; j < K - 1; j++)
          hist[r][j] <= nwin[r][j+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && (col == COL_LAST) && (row == ROW_LAST);
      if (accept && complete) begin
        out_valid  <= 1'b1;
        out_window <= win_flat;
        out_row    <= cur_or;
        out_col    <= cur_oc;
      end else begin
`ifdef CONV_WINDOW_GEN_BP_EN
        if (out_ready) out_valid <= 1'b0;
`else
        out_valid <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - directed self-checking bench for conv_window_gen
// Runs default parameters plus a STRIDE=2 instance; backpressure steps under CONV_WINDOW_GEN_BP_EN.
module tb_conv_window_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready, in_ready2;
  logic [31:0]  in_data;
  logic         out_valid, out_valid2;
  logic [287:0] out_window, out_window2;
  logic [4:0]   out_row, out_row2, out_col, out_col2;
  logic         frame_done, frame_done2;
  logic         hs, in_valid2;
`ifdef CONV_WINDOW_GEN_BP_EN
  logic         out_ready;
  assign hs        = out_valid && out_ready;
  assign in_valid2 = in_valid && in_ready;
`else
  assign hs        = out_valid;
  assign in_valid2 = in_valid;
`endif

  always #5 clk = ~clk;

  conv_window_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid),
`ifdef CONV_WINDOW_GEN_BP_EN
    .out_ready(out_ready),
`endif
    .out_window(out_window), .out_row(out_row), .out_col(out_col), .frame_done(frame_done));

  conv_window_gen #(.STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2),
`ifdef CONV_WINDOW_GEN_BP_EN
    .out_ready(1'b1),
`endif
    .out_window(out_window2), .out_row(out_row2), .out_col(out_col2), .frame_done(frame_done2));

  int pass_cnt = 0, total_cnt = 0;
  int timeouts = 0;
  int last_pix = -1, fd_cnt = 0, fd_pix = -1;
  int w_pix[$], s_pix[$];
  logic [4:0] w_row[$], w_col[$], s_row[$], s_col[$];
  logic [287:0] w_win[$], s_win[$];

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [287:0] exp_win(input int orow, input int ocol, input int s);
    logic [287:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*32 +: 32] = 32'((s*orow + r)*28 + s*ocol + c);
    return w;
  endfunction

  // Outputs are sampled before the pixel about to be accepted updates last_pix.
  always @(negedge clk) begin
    if (hs) begin
      w_pix.push_back(last_pix); w_row.push_back(out_row);
      w_col.push_back(out_col);  w_win.push_back(out_window);
    end
    if (out_valid2) begin
      s_pix.push_back(last_pix); s_row.push_back(out_row2);
      s_col.push_back(out_col2); s_win.push_back(out_window2);
    end
    if (frame_done) begin fd_cnt++; fd_pix = last_pix; end
    if (in_valid && in_ready) last_pix = int'(in_data);
  end

  task automatic clear_capture();
    w_pix.delete(); w_row.delete(); w_col.delete(); w_win.delete();
    s_pix.delete(); s_row.delete(); s_col.delete(); s_win.delete();
    fd_cnt = 0; fd_pix = -1; timeouts = 0;
  endtask

  task automatic send_pix(input int p, input bit gaps);
    bit ok;
    int n;
    if (gaps && $urandom_range(1) == 0) begin
      in_valid = 1'b0; in_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = 32'(p);
    n = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 1000);
    if (!ok) timeouts++;
  endtask

  task automatic send_frame(input bit gaps);
    for (int p = 0; p < 784; p++) send_pix(p, gaps);
    in_valid = 1'b0;
  endtask

  task automatic check_frames(input int nf);
    int m, ms, n59;
    m = 0; ms = 0; n59 = 0;
    chk("input_timeouts", timeouts, 0);
    chk("window_count", w_win.size(), 676*nf);
    for (int i = 0; i < w_win.size(); i++) begin
      int j;
      j = i % 676;
      if (w_row[i] !== 5'(j/26) || w_col[i] !== 5'(j%26) || w_win[i] !== exp_win(j/26, j%26, 1)) m++;
    end
    chk("window_sequence_mismatches", m, 0);
    chk("frame_done_count", fd_cnt, nf);
    chk("frame_done_after_pixel", fd_pix, 783);
    chk("stride2_window_count", s_win.size(), 169*nf);
    for (int i = 0; i < s_win.size(); i++) begin
      int j;
      j = i % 169;
      if (s_row[i] !== 5'(j/13) || s_col[i] !== 5'(j%13) || s_win[i] !== exp_win(j/13, j%13, 2)) ms++;
      if (s_pix[i] == 59 || s_pix[i] == 86) n59++;
    end
    chk("stride2_sequence_mismatches", ms, 0);
    chk("stride2_no_window_at_59_86", n59, 0);
  endtask

  task automatic check_first_last();
    if (w_win.size() > 0) begin
      chk("first_window_pixel", w_pix[0], 58);
      chk("first_window_data", w_win[0], exp_win(0, 0, 1));
      chk("first_window_row", w_row[0], 0);
      chk("first_window_col", w_col[0], 0);
      chk("last_window_row", w_row[w_row.size()-1], 25);
      chk("last_window_col", w_col[w_col.size()-1], 25);
      chk("last_window_elem22", w_win[w_win.size()-1][8*32 +: 32], 783);
    end else chk("first_window_present", 0, 1);
    if (s_win.size() > 1) begin
      chk("stride2_second_pixel", s_pix[1], 60);
      chk("stride2_second_col", s_col[1], 1);
    end else chk("stride2_second_present", 0, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
`ifdef CONV_WINDOW_GEN_BP_EN
    out_ready = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_window", out_window, 0);
    chk("reset_out_row", out_row, 0);
    chk("reset_out_col", out_col, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_in_ready", in_ready, 1);

    // Continuous frame
    clear_capture();
    send_frame(1'b0);
    repeat (4) @(posedge clk); #1;
    check_first_last();
    check_frames(1);

    // Partial frame, then reset and a fresh frame
    for (int p = 0; p < 100; p++) send_pix(p, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_out_valid", out_valid, 0);
    clear_capture();
    send_frame(1'b0);
    repeat (4) @(posedge clk); #1;
    check_first_last();
    check_frames(1);

    // Two back-to-back frames with random input gaps
    clear_capture();
    send_frame(1'b1);
    send_frame(1'b1);
    repeat (4) @(posedge clk); #1;
    check_frames(2);

`ifdef CONV_WINDOW_GEN_BP_EN
    clear_capture();
    out_ready = 1'b0;
    fork
      send_frame(1'b0);
      begin
        int n, m;
        logic [287:0] w0;
        n = 0; m = 0;
        while (!out_valid && n < 2000) begin @(posedge clk); #1; n++; end
        chk("bp_first_window_seen", out_valid, 1);
        w0 = out_window;
        chk("bp_first_window_data", w0, exp_win(0, 0, 1));
        repeat (10) begin
          @(negedge clk);
          if (out_window !== w0 || in_ready !== 1'b0 || out_valid !== 1'b1) m++;
        end
        chk("bp_hold_stable", m, 0);
        @(posedge clk); #1; out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_input_timeouts", timeouts, 0);
    chk("bp_window_count", w_win.size(), 676);
    if (w_win.size() > 1) begin
      chk("bp_second_pixel", w_pix[1], 59);
      chk("bp_second_window", w_win[1], exp_win(0, 1, 1));
    end else chk("bp_second_present", 0, 1);
    begin
      int m;
      m = 0;
      for (int i = 0; i < w_win.size(); i++)
        if (w_row[i] !== 5'(i/26) || w_col[i] !== 5'(i%26) || w_win[i] !== exp_win(i/26, i%26, 1)) m++;
      chk("bp_sequence_mismatches", m, 0);
    end
    chk("bp_frame_done_count", fd_cnt, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
